// File: rtl/qosc_monitor_if.sv
// ============================================================================
//  Module      : qosc_monitor_if
//  Description : Sample stream, band setup and lock-status bundle for the
//                quadrature-oscillator monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface qosc_monitor_if;
    logic        sample_valid;
    logic [7:0]  accu_re;
    logic [7:0]  accu_im;
    logic [15:0] target_sq;
    logic [15:0] tol_sq;
    logic [15:0] mag_sq;
    logic        mag_valid;
    logic        amp_low;
    logic        amp_high;
    logic [7:0]  period;
    logic        period_valid;
    logic        locked;
    logic        lost_lock;

    modport master (
        output sample_valid, accu_re, accu_im, target_sq, tol_sq,
        input  mag_sq, mag_valid, amp_low, amp_high,
        input  period, period_valid, locked, lost_lock
    );

    modport slave (
        input  sample_valid, accu_re, accu_im, target_sq, tol_sq,
        output mag_sq, mag_valid, amp_low, amp_high,
        output period, period_valid, locked, lost_lock
    );
endinterface

`default_nettype wire

// File: rtl/qosc_monitor.sv
// ============================================================================
//  Module      : qosc_monitor
//  Description : Tracks oscillator amplitude against a band and period via
//                rising zero crossings; declares lock when both are stable.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module qosc_monitor #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned PERIOD_TOL = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    qosc_monitor_if.slave bus
);

    localparam logic [3:0] c_lock_count = 4'(LOCK_COUNT);
    localparam logic [7:0] c_period_tol = 8'(PERIOD_TOL);
    localparam logic [7:0] c_cnt_max    = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        v1_q;
    logic [15:0] re_sq_q, im_sq_q;
    logic        mag_valid_q;
    logic [15:0] mag_sq_q;
    logic        amp_low_q, amp_high_q;
    logic        sign_q;
    logic        armed_q;
    logic        period_seen_q;
    logic [7:0]  cnt_q;
    logic [7:0]  period_q;
    logic        period_valid_q;
    logic [3:0]  match_cnt_q, match_cnt_d;
    logic        lost_lock_q, lost_lock_d;

    logic signed [15:0] w_re_ext, w_im_ext;
    logic signed [15:0] w_re_prod, w_im_prod;
    logic [15:0] w_mag;
    logic [16:0] w_lo_full, w_hi_full;
    logic [15:0] w_lo, w_hi;
    logic        w_cross, w_period_evt, w_match, w_mismatch, w_band_fault;
    logic [7:0]  w_cnt_inc, w_diff;

    // Magnitude datapath: squares in stage 1, sum and band compare in stage 2
    assign w_re_ext  = {{8{bus.accu_re[7]}}, bus.accu_re};
    assign w_im_ext  = {{8{bus.accu_im[7]}}, bus.accu_im};
    assign w_re_prod = w_re_ext * w_re_ext;
    assign w_im_prod = w_im_ext * w_im_ext;
    assign w_mag     = re_sq_q + im_sq_q;

    assign w_lo_full = {1'b0, bus.target_sq} - {1'b0, bus.tol_sq};
    assign w_hi_full = {1'b0, bus.target_sq} + {1'b0, bus.tol_sq};
    assign w_lo      = w_lo_full[16] ? 16'h0000 : w_lo_full[15:0];
    assign w_hi      = w_hi_full[16] ? 16'hFFFF : w_hi_full[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            re_sq_q     <= 16'h0000;
            im_sq_q     <= 16'h0000;
            mag_valid_q <= 1'b0;
            mag_sq_q    <= 16'h0000;
            amp_low_q   <= 1'b0;
            amp_high_q  <= 1'b0;
        end else begin
            v1_q        <= bus.sample_valid;
            mag_valid_q <= v1_q;
            if (bus.sample_valid) begin
                re_sq_q <= w_re_prod;
                im_sq_q <= w_im_prod;
            end
            if (v1_q) begin
                mag_sq_q   <= w_mag;
                amp_low_q  <= (w_mag < w_lo);
                amp_high_q <= (w_mag > w_hi);
            end
        end
    end

    // Period measurement; a saturated count of 255 never matches anything
    assign w_cross      = bus.sample_valid & sign_q & ~bus.accu_re[7];
    assign w_cnt_inc    = (cnt_q == c_cnt_max) ? c_cnt_max : cnt_q + 8'd1;
    assign w_period_evt = w_cross & armed_q;
    assign w_diff       = (w_cnt_inc >= period_q) ? (w_cnt_inc - period_q)
                                                  : (period_q - w_cnt_inc);
    assign w_match      = w_period_evt & period_seen_q
                        & (w_cnt_inc != c_cnt_max) & (period_q != c_cnt_max)
                        & (w_diff <= c_period_tol);
    assign w_mismatch   = w_period_evt & ~w_match;
    assign w_band_fault = mag_valid_q & (amp_low_q | amp_high_q);

    always_comb begin
        match_cnt_d = match_cnt_q;
        if (w_mismatch) begin
            match_cnt_d = 4'd0;
        end else if (w_match) begin
            match_cnt_d = (match_cnt_q >= c_lock_count) ? c_lock_count
                                                        : match_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q         <= 1'b0;
            armed_q        <= 1'b0;
            period_seen_q  <= 1'b0;
            cnt_q          <= 8'h00;
            period_q       <= 8'h00;
            period_valid_q <= 1'b0;
            match_cnt_q    <= 4'd0;
        end else begin
            period_valid_q <= w_period_evt;
            match_cnt_q    <= match_cnt_d;
            if (bus.sample_valid) begin
                sign_q <= bus.accu_re[7];
                cnt_q  <= w_cross ? 8'h00 : w_cnt_inc;
            end
            if (w_cross) begin
                armed_q <= 1'b1;
            end
            if (w_period_evt) begin
                period_q      <= w_cnt_inc;
                period_seen_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lost_lock_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_cross) begin
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (w_match && (match_cnt_d == c_lock_count) && !amp_low_q && !amp_high_q) begin
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (w_mismatch || w_band_fault) begin
                    state_d     = S_MEASURE;
                    lost_lock_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lost_lock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lost_lock_q <= lost_lock_d;
        end
    end

    assign bus.mag_sq       = mag_sq_q;
    assign bus.mag_valid    = mag_valid_q;
    assign bus.amp_low      = amp_low_q;
    assign bus.amp_high     = amp_high_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = (state_q == S_LOCKED);
    assign bus.lost_lock    = lost_lock_q;

endmodule

`default_nettype wire

// File: tb/tb_qosc_monitor.sv
// ============================================================================
//  Module      : tb_qosc_monitor
//  Description : Self-checking bench for qosc_monitor (vector table + scoreboard).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_qosc_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qosc_monitor_if bus();

    qosc_monitor #(.LOCK_COUNT(4), .PERIOD_TOL(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  re;
        logic [7:0]  im;
        logic [15:0] tgt;
        logic [15:0] tol;
        logic [15:0] mag;
        logic        lo;
        logic        hi;
    } vec_t;

    typedef struct {
        logic [15:0] mag;
        logic        lo;
        logic        hi;
        int          due;
    } mexp_t;

    typedef struct {
        logic [7:0] per;
        int         due;
    } pexp_t;

    vec_t  tbl [12];
    mexp_t mq[$];
    pexp_t pq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lost_seen = 0;
    int pulses_seen = 0;

    bit m_sign;
    bit m_armed;
    int m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 32'({bus.mag_sq, bus.mag_valid, bus.amp_low, bus.amp_high, bus.period,
                       bus.period_valid, bus.locked, bus.lost_lock}), 32'h0);
    endtask

    // Observe outputs at the falling edge, then advance to just past the rising edge
    task automatic tick();
        mexp_t me;
        pexp_t pe;
        @(negedge clk);
        if (bus.lost_lock) lost_seen++;
        if (bus.mag_valid || bus.period_valid) pulses_seen++;
        if (bus.mag_valid) begin
            if (mq.size() == 0) begin
                chk("mag_unexpected", 32'(bus.mag_sq), 32'hFFFF_FFFF);
            end else begin
                me = mq.pop_front();
                chk("mag_sq", 32'(bus.mag_sq), 32'(me.mag));
                chk("amp_low", 32'(bus.amp_low), 32'(me.lo));
                chk("amp_high", 32'(bus.amp_high), 32'(me.hi));
                chk("mag_latency", 32'(cyc), 32'(me.due));
            end
        end
        while (mq.size() > 0 && mq[0].due < cyc) begin
            me = mq.pop_front();
            chk("mag_missing", 32'(cyc), 32'(me.due));
        end
        if (bus.period_valid) begin
            if (pq.size() == 0) begin
                chk("period_unexpected", 32'(bus.period), 32'hFFFF_FFFF);
            end else begin
                pe = pq.pop_front();
                chk("period", 32'(bus.period), 32'(pe.per));
                chk("period_latency", 32'(cyc), 32'(pe.due));
            end
        end
        while (pq.size() > 0 && pq[0].due < cyc) begin
            pe = pq.pop_front();
            chk("period_missing", 32'(cyc), 32'(pe.due));
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive_exp(input logic [7:0] re, input logic [7:0] im,
                             input logic [15:0] mag, input logic lo, input logic hi);
        mexp_t me;
        pexp_t pe;
        bus.sample_valid = 1'b1;
        bus.accu_re      = re;
        bus.accu_im      = im;
        me.mag = mag; me.lo = lo; me.hi = hi; me.due = cyc + 2;
        mq.push_back(me);
        if (m_sign && !re[7]) begin
            if (m_armed) begin
                pe.per = (m_cnt >= 254) ? 8'hFF : 8'(m_cnt + 1);
                pe.due = cyc + 1;
                pq.push_back(pe);
            end
            m_cnt   = 0;
            m_armed = 1'b1;
        end else begin
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
        m_sign = re[7];
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic drive(input logic [7:0] re, input logic [7:0] im);
        int r, i, m, lo, hi;
        r  = int'($signed(re));
        i  = int'($signed(im));
        m  = r * r + i * i;
        lo = int'(bus.target_sq) - int'(bus.tol_sq);
        if (lo < 0) lo = 0;
        hi = int'(bus.target_sq) + int'(bus.tol_sq);
        if (hi > 65535) hi = 65535;
        drive_exp(re, im, 16'(m), (m < lo), (m > hi));
    endtask

    task automatic neg_run(input int n);
        repeat (n) drive(8'hE0, 8'h00);
    endtask

    task automatic pos_run(input int n);
        repeat (n) drive(8'h20, 8'h00);
    endtask

    task automatic model_clear();
        mq.delete();
        pq.delete();
        m_sign  = 1'b0;
        m_armed = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic do_reset();
        bus.sample_valid = 1'b0;
        rst_n = 1'b0;
        model_clear();
        repeat (3) tick();
        chk_outputs_zero("reset_outputs");
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        re     im     target    tol       mag       lo    hi
        tbl[0]  = '{8'h20, 8'h00, 16'h0400, 16'h0100, 16'h0400, 1'b0, 1'b0};
        tbl[1]  = '{8'h80, 8'h80, 16'h0400, 16'h0100, 16'h8000, 1'b0, 1'b1};
        tbl[2]  = '{8'h00, 8'h00, 16'h0010, 16'h0100, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{8'h00, 8'h00, 16'h0200, 16'h0100, 16'h0000, 1'b1, 1'b0};
        tbl[4]  = '{8'h10, 8'h10, 16'h0200, 16'h0000, 16'h0200, 1'b0, 1'b0};
        tbl[5]  = '{8'h10, 8'h11, 16'h0200, 16'h0000, 16'h0221, 1'b0, 1'b1};
        tbl[6]  = '{8'h10, 8'h0F, 16'h0200, 16'h0000, 16'h01E1, 1'b1, 1'b0};
        tbl[7]  = '{8'hE0, 8'h00, 16'hFF00, 16'h0200, 16'h0400, 1'b1, 1'b0};
        tbl[8]  = '{8'h7F, 8'h7F, 16'h7E02, 16'hFFFF, 16'h7E02, 1'b0, 1'b0};
        tbl[9]  = '{8'h81, 8'h00, 16'h3F00, 16'h0001, 16'h3F01, 1'b0, 1'b0};
        tbl[10] = '{8'hFF, 8'hFF, 16'h0003, 16'h0001, 16'h0002, 1'b0, 1'b0};
        tbl[11] = '{8'h01, 8'h00, 16'h0003, 16'h0001, 16'h0001, 1'b1, 1'b0};

        bus.sample_valid = 1'b1;
        bus.accu_re      = 8'h80;
        bus.accu_im      = 8'h7F;
        bus.target_sq    = 16'h0400;
        bus.tol_sq       = 16'h0100;
        model_clear();
        repeat (3) tick();
        chk_outputs_zero("reset_initial");
        bus.sample_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Isolated vectors: band inputs stay put until stage 2 has consumed them
        for (int k = 0; k < 12; k++) begin
            bus.target_sq = tbl[k].tgt;
            bus.tol_sq    = tbl[k].tol;
            drive_exp(tbl[k].re, tbl[k].im, tbl[k].mag, tbl[k].lo, tbl[k].hi);
            tick();
            tick();
        end
        repeat (2) tick();

        // Back-to-back random stream through the full pipeline
        bus.target_sq = 16'h0400;
        bus.tol_sq    = 16'h0100;
        repeat (40) drive(8'($urandom), 8'($urandom));
        repeat (4) tick();

        // Lock acquisition with {4 negative, 4 non-negative}
        do_reset();
        tick();
        repeat (5) begin neg_run(4); pos_run(4); end
        neg_run(4);
        chk("locked_before_6th", 32'(bus.locked), 32'd0);
        pos_run(1);
        chk("locked_after_6th", 32'(bus.locked), 32'd1);
        pos_run(3);

        // One period of 11 breaks lock
        lost_seen = 0;
        neg_run(7);
        pos_run(1);
        chk("lost_lock_pulse", 32'(bus.lost_lock), 32'd1);
        chk("locked_dropped", 32'(bus.locked), 32'd0);
        pos_run(3);
        chk("lost_lock_single", 32'(bus.lost_lock), 32'd0);
        neg_run(4); pos_run(4);
        repeat (3) begin neg_run(4); pos_run(4); end
        chk("relock_not_early", 32'(bus.locked), 32'd0);
        neg_run(4);
        pos_run(1);
        chk("relock", 32'(bus.locked), 32'd1);
        chk("lost_lock_count", 32'(lost_seen), 32'd1);
        pos_run(3);

        // Long negative stretch saturates the period at 255 and drops lock
        neg_run(300);
        chk("locked_through_long_neg", 32'(bus.locked), 32'd1);
        pos_run(1);
        chk("period_saturated", 32'(bus.period), 32'd255);
        chk("lost_on_sat_period", 32'(bus.lost_lock), 32'd1);
        chk("unlocked_on_sat_period", 32'(bus.locked), 32'd0);
        pos_run(3);

        // Asynchronous reset with samples and a period pulse in flight
        neg_run(4);
        pos_run(1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("reset_midstream");
        model_clear();
        pulses_seen = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("no_stale_pulses", 32'(pulses_seen), 32'd0);
        chk_outputs_zero("outputs_after_release");
        chk("mag_queue_empty", 32'(mq.size()), 32'd0);
        chk("period_queue_empty", 32'(pq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qosc_monitor.md
QOSC_MONITOR -- requirements
Module: qosc_monitor

Interface
REQ-001 Parameter LOCK_COUNT, default 4: consecutive matching periods required to declare lock (range 1..15).
REQ-002 Parameter PERIOD_TOL, default 1: max absolute difference, in samples, between successive periods that still counts as a match.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port sample_valid  in  1  one-cycle strobe per oscillator step; back-to-back strobes allowed.
REQ-006 Port accu_re  in  8  oscillator real part, signed two's complement.
REQ-007 Port accu_im  in  8  oscillator imaginary part, signed two's complement.
REQ-008 Port target_sq  in  16  target squared magnitude, unsigned.
REQ-009 Port tol_sq  in  16  allowed deviation around target_sq, unsigned.
REQ-010 Port mag_sq  out  16  re^2+im^2 of the latest sample, unsigned.
REQ-011 Port mag_valid  out  1  one-cycle pulse when mag_sq, amp_low and amp_high update.
REQ-012 Port amp_low / amp_high  out  1 each  magnitude below / above the tolerance band.
REQ-013 Port period  out  8  samples between the last two rising zero crossings of accu_re.
REQ-014 Port period_valid  out  1  one-cycle pulse when period updates.
REQ-015 Port locked  out  1  high while the FSM is in LOCKED.
REQ-016 Port lost_lock  out  1  one-cycle pulse on the LOCKED->MEASURE transition.

Function
REQ-017 Magnitude pipeline: stage 1 registers re^2 and im^2 (each unsigned, max 16384); stage 2 registers their sum into mag_sq; mag_valid asserts exactly 2 cycles after the sample_valid it belongs to.
REQ-018 The pipeline accepts a new sample every cycle, with no stalls or drops; mag_sq holds its value between mag_valid pulses.
REQ-019 Band check uses 17-bit arithmetic: lo = target_sq - tol_sq, saturated at 0; hi = target_sq + tol_sq, saturated at 16'hFFFF.
REQ-020 The band flags update with mag_valid: amp_low = mag_sq < lo, amp_high = mag_sq > hi; boundary values equal to lo or hi are in band.
REQ-021 Rising crossing: the previous valid sample has accu_re[7]=1 and the current valid sample has accu_re[7]=0; detection happens only on sample_valid.
REQ-022 Sample counter cnt: 8-bit, saturates at 255; on a crossing, period is loaded with min(cnt+1, 255) and cnt is cleared; on other valid samples, cnt increments.
REQ-023 An armed flag is cleared by reset and set by the first crossing; the first crossing only arms the counter, and outputs no period.
REQ-024 period_valid asserts 1 cycle after the sample_valid that completes a period.
REQ-025 A match is |period_new - period_prev| <= PERIOD_TOL, with neither value equal to 255; the first period after arming is never a match.
REQ-026 match_cnt: increments on a match, saturating at LOCK_COUNT; clears on a mismatch.
REQ-027 FSM state IDLE (after reset): goes to MEASURE on the first crossing.
REQ-028 FSM state MEASURE: goes to LOCKED in the cycle match_cnt reaches LOCK_COUNT, provided the most recent band check had amp_low=0 and amp_high=0.
REQ-029 FSM state LOCKED: goes to MEASURE, pulsing lost_lock, on either a mismatch period or a mag_valid with amp_low or amp_high set.
REQ-030 If a mismatch and a band fault occur in the same cycle, the FSM makes one transition and lost_lock produces a single pulse.
REQ-031 With no sample_valid, no state changes except draining of the magnitude pipeline.

Reset
REQ-032 While rst_n=0, all outputs are 0, cnt=0, match_cnt=0, armed=0, previous-sample sign=0, pipeline valid bits=0 and the FSM is in IDLE.
REQ-033 Reset asserted mid-operation aborts in-flight samples: no mag_valid or period_valid pulse follows the release of reset.
REQ-034 The first sample_valid accepted is the one sampled at or after the first rising clk edge with rst_n=1.

Verification
REQ-035 re=8'h20, im=8'h00 on one strobe -> mag_sq=16'h0400 with mag_valid 2 cycles later.
REQ-036 re=8'h80, im=8'h80 -> mag_sq=16'h8000; with target_sq=16'h0400 and tol_sq=16'h0100, amp_high=1 and amp_low=0.
REQ-037 target_sq=16'h0010, tol_sq=16'h0100, mag_sq=0 -> lo saturates to 0 and amp_low=0.
REQ-038 re repeating {4 negative, 4 non-negative}, in band, LOCK_COUNT=4 -> period=8 from the 2nd crossing; locked=1 one cycle after the strobe of the 6th crossing.
REQ-039 From LOCKED, insert one period of 11 -> lost_lock pulses once, locked=0, match_cnt=0; relock after 4 further matching periods.
REQ-040 re held negative for 300 strobes, then a crossing -> period=255, counted as a mismatch; rst_n pulsed low mid-stream -> all outputs 0 and no stale valid pulses.
